// File: rtl/spi_mem_responder_if.sv
// spi_mem_responder_if: SPI pins and on-chip memory port of the SPI memory responder
interface spi_mem_responder_if #(parameter int ADDR_W = 16);
  logic              sclk_in;
  logic              cs_n_in;
  logic              mosi_in;
  logic              miso_out;
  logic              miso_oe_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_rd_en_out;
  logic              mem_wr_en_out;
  logic [7:0]        mem_wdata_out;
  logic [7:0]        mem_rdata_in;
  logic              mem_rdata_valid_in;
  logic              busy_out;
  logic              cmd_error_out;
  modport slave (
    input  sclk_in, cs_n_in, mosi_in, mem_rdata_in, mem_rdata_valid_in,
    output miso_out, miso_oe_out, mem_addr_out, mem_rd_en_out, mem_wr_en_out,
           mem_wdata_out, busy_out, cmd_error_out
  );
  modport master (
    output sclk_in, cs_n_in, mosi_in, mem_rdata_in, mem_rdata_valid_in,
    input  miso_out, miso_oe_out, mem_addr_out, mem_rd_en_out, mem_wr_en_out,
           mem_wdata_out, busy_out, cmd_error_out
  );
endinterface

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: oversampled SPI mode-0 slave serving READ 0x03 / WRITE 0x02 from a memory port
module spi_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_in,
  input logic reset_in,
  spi_mem_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE} state_t;
  state_t r_state, w_state;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_cs_s, r_mosi_s;
  logic r_sclk_d;
  logic w_sclk, w_cs_n, w_mosi, w_rise, w_fall, w_have;
  logic [4:0] r_cnt, w_cnt;
  logic [ADDR_W-2:0] r_sh, w_sh;
  logic [ADDR_W-1:0] w_sh_in, r_addr, w_addr, r_maddr, w_maddr;
  logic [7:0] r_buf, w_buf, r_tx, w_tx, r_wdata, w_wdata, w_byte;
  logic r_rd, w_rd, r_bufv, w_bufv, r_miso, w_miso, r_oe, w_oe;
  logic r_rd_en, w_rd_en, r_wr_en, w_wr_en, r_err, w_err;
  assign w_sclk  = r_sclk_s[SYNC_STAGES-1];
  assign w_cs_n  = r_cs_s[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_s[SYNC_STAGES-1];
  assign w_rise  = w_sclk & ~r_sclk_d;
  assign w_fall  = ~w_sclk & r_sclk_d;
  assign w_sh_in = {r_sh, w_mosi};
  assign w_have  = r_bufv | bus.mem_rdata_valid_in;
  assign w_byte  = r_bufv ? r_buf : bus.mem_rdata_in;
  // pin synchronisers; CS resets deasserted so reset release never looks like a select
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], bus.sclk_in};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], bus.cs_n_in};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], bus.mosi_in};
      r_sclk_d <= w_sclk;
    end
  // protocol state and registered outputs
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_addr  <= '0;
      r_maddr <= '0;
      r_buf   <= '0;
      r_tx    <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_bufv  <= 1'b0;
      r_miso  <= 1'b0;
      r_oe    <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_addr  <= w_addr;
      r_maddr <= w_maddr;
      r_buf   <= w_buf;
      r_tx    <= w_tx;
      r_wdata <= w_wdata;
      r_rd    <= w_rd;
      r_bufv  <= w_bufv;
      r_miso  <= w_miso;
      r_oe    <= w_oe;
      r_rd_en <= w_rd_en;
      r_wr_en <= w_wr_en;
      r_err   <= w_err;
    end
  // next state: CS high overrides everything, including a coincident SCLK edge
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_addr  = r_addr;
    w_maddr = r_maddr;
    w_buf   = r_buf;
    w_tx    = r_tx;
    w_wdata = r_wdata;
    w_rd    = r_rd;
    w_bufv  = r_bufv;
    w_miso  = r_miso;
    w_oe    = r_oe;
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_err   = 1'b0;
    if (w_cs_n) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_miso  = 1'b0;
      w_oe    = 1'b0;
      w_bufv  = 1'b0;
    end else
      case (r_state)
        IDLE: begin
          w_state = CMD;
          w_cnt   = '0;
        end
        CMD: if (w_rise) begin
          w_sh  = w_sh_in[ADDR_W-2:0];
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd7) begin
            w_cnt   = '0;
            w_rd    = w_sh_in[7:0] == 8'h03;
            w_state = (w_sh_in[7:0] == 8'h03 || w_sh_in[7:0] == 8'h02) ? ADDR : IGNORE;
            w_err   = w_sh_in[7:0] != 8'h03 && w_sh_in[7:0] != 8'h02;
          end
        end
        ADDR: if (w_rise) begin
          w_sh  = w_sh_in[ADDR_W-2:0];
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            w_cnt   = '0;
            w_addr  = w_sh_in;
            w_maddr = r_rd ? w_sh_in : r_maddr;
            w_rd_en = r_rd;
            w_bufv  = 1'b0;
            w_state = r_rd ? RD_DATA : WR_DATA;
          end
        end
        RD_DATA: begin
          if (bus.mem_rdata_valid_in) begin
            w_buf  = bus.mem_rdata_in;
            w_bufv = 1'b1;
          end
          if (w_fall) begin
            w_oe = 1'b1;
            if (r_cnt[2:0] == 3'd0) begin
              w_miso = w_have & w_byte[7];
              w_tx   = w_have ? {w_byte[6:0], 1'b0} : 8'h00;
              w_bufv = 1'b0;
              w_err  = ~w_have;
            end else begin
              w_miso = r_tx[7];
              w_tx   = {r_tx[6:0], 1'b0};
            end
          end
          if (w_rise) begin
            w_cnt = (r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
              w_addr  = r_addr + 1'b1;
              w_maddr = r_addr + 1'b1;
              w_rd_en = 1'b1;
            end
          end
        end
        WR_DATA: if (w_rise) begin
          w_sh  = w_sh_in[ADDR_W-2:0];
          w_cnt = (r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
          if (r_cnt == 5'd7) begin
            w_wr_en = 1'b1;
            w_wdata = w_sh_in[7:0];
            w_maddr = r_addr;
            w_addr  = r_addr + 1'b1;
          end
        end
        IGNORE: ;
        default: w_state = IDLE;
      endcase
  end
  assign bus.miso_out      = r_miso;
  assign bus.miso_oe_out   = r_oe;
  assign bus.mem_addr_out  = r_maddr;
  assign bus.mem_rd_en_out = r_rd_en;
  assign bus.mem_wr_en_out = r_wr_en;
  assign bus.mem_wdata_out = r_wdata;
  assign bus.busy_out      = r_state != IDLE;
  assign bus.cmd_error_out = r_err;
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: transaction-level model and memory emulator checking the SPI memory responder
module tb_spi_mem_responder;
  localparam int H    = 5;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_mem_responder_if #(.ADDR_W(16)) bus();
  spi_mem_responder #(.ADDR_W(16), .SYNC_STAGES(SYNC)) dut (.clk_in(clk), .reset_in(rst), .bus(bus));
  int total = 0;
  int bad   = 0;
  logic [7:0] mem [65536];
  logic [7:0] ref_mem [65536];
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];
  logic [7:0] exp_rb [8];
  logic [15:0] exp_rd [$];
  logic [23:0] exp_wr [$];
  int err_seen = 0;
  int rd_seen  = 0;
  int wr_seen  = 0;
  logic [15:0] rd_first = '0;
  logic rd_first_set = 1'b0;
  logic oe_ok    = 1'b0;
  logic withhold = 1'b0;
  int lat_fix    = 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // memory emulator: applies write strobes and answers reads 1 or 2 cycles later
  initial begin
    bus.mem_rdata_valid_in = 1'b0;
    bus.mem_rdata_in = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.mem_wr_en_out) mem[bus.mem_addr_out] = bus.mem_wdata_out;
      if (!rst && bus.mem_rd_en_out && !withhold) begin
        automatic logic [15:0] a = bus.mem_addr_out;
        automatic int lat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 2));
        repeat (lat) @(posedge clk);
        #1;
        bus.mem_rdata_valid_in = 1'b1;
        bus.mem_rdata_in = mem[a];
        @(posedge clk);
        #1;
        bus.mem_rdata_valid_in = 1'b0;
      end
    end
  end
  // per-cycle compare of memory strobes and pad behaviour against the model's expectations
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.mem_rd_en_out || bus.mem_wr_en_out)
        chk("strobe_excl", 32'(bus.mem_rd_en_out & bus.mem_wr_en_out), 0);
      if (bus.mem_rd_en_out) begin
        rd_seen++;
        if (!rd_first_set) begin
          rd_first = bus.mem_addr_out;
          rd_first_set = 1'b1;
        end
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got addr %0h want no read", bus.mem_addr_out);
        end else chk("rd_addr", 32'(bus.mem_addr_out), 32'(exp_rd.pop_front()));
      end
      if (bus.mem_wr_en_out) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected: got %0h/%0h want no write", bus.mem_addr_out, bus.mem_wdata_out);
        end else chk("wr_addr_data", {8'h00, bus.mem_addr_out, bus.mem_wdata_out}, {8'h00, exp_wr.pop_front()});
      end
      if (bus.cmd_error_out) err_seen++;
      if (!oe_ok) chk("pads_quiet", {30'd0, bus.miso_oe_out, bus.miso_out}, 0);
    end
  end
  task automatic spi_bit(input logic b, output logic r, input logic chk_oe);
    bus.mosi_in = b;
    repeat (H) @(negedge clk);
    r = bus.miso_out;
    if (chk_oe) chk("miso_oe_data", 32'(bus.miso_oe_out), 1);
    bus.sclk_in = 1'b1;
    repeat (H) @(negedge clk);
    bus.sclk_in = 1'b0;
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, input logic chk_oe);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, chk_oe);
      rx[i] = r;
    end
  endtask
  // one CS-framed transaction; expectations come from the command rules, not from the DUT
  task automatic txn(input logic [7:0] op, input logic [23:0] a, input int n, input int tail);
    int e0 = err_seen;
    int exp_err = 0;
    logic [15:0] b = a[15:0];
    logic [7:0] x;
    logic y;
    rd_first_set = 1'b0;
    if (op == 8'h03) begin
      for (int k = 0; k <= n; k++) exp_rd.push_back(16'(b + k));
      for (int k = 0; k < n; k++) exp_rb[k] = withhold ? 8'h00 : ref_mem[16'(b + k)];
      // every byte start, including the one opened by the closing SCLK fall, underruns
      exp_err = withhold ? n + 1 : 0;
    end else if (op == 8'h02) begin
      for (int k = 0; k < n; k++) begin
        exp_wr.push_back({16'(b + k), wbuf[k]});
        ref_mem[16'(b + k)] = wbuf[k];
      end
    end else exp_err = 1;
    bus.cs_n_in = 1'b0;
    repeat (H) @(negedge clk);
    spi_byte(op, x, 1'b0);
    if (op == 8'h03 || op == 8'h02) begin
      spi_byte(a[23:16], x, 1'b0);
      spi_byte(a[15:8], x, 1'b0);
      if (op == 8'h03) oe_ok = 1'b1;
      spi_byte(a[7:0], x, 1'b0);
      for (int k = 0; k < n; k++) begin
        spi_byte(op == 8'h03 ? 8'($urandom) : wbuf[k], x, op == 8'h03);
        rbuf[k] = x;
        if (op == 8'h03) chk("rd_byte", 32'(x), 32'(exp_rb[k]));
      end
      for (int i = 0; i < tail; i++) spi_bit(1'($urandom), y, op == 8'h03);
    end else begin
      for (int k = 0; k < 4; k++) spi_byte(8'($urandom), x, 1'b0);
      chk("busy_ignore", 32'(bus.busy_out), 1);
    end
    repeat (H) @(negedge clk);
    bus.cs_n_in = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("busy_release", 32'(bus.busy_out), 0);
    repeat (4) @(negedge clk);
    oe_ok = 1'b0;
    chk("err_count", 32'(err_seen - e0), 32'(exp_err));
    chk("rd_left", 32'(exp_rd.size()), 0);
    chk("wr_left", 32'(exp_wr.size()), 0);
    exp_rd.delete();
    exp_wr.delete();
  endtask
  initial begin
    int e0, r0, w0, kind, n;
    logic [7:0] op;
    logic [23:0] a;
    logic y;
    logic [7:0] x;
    bus.sclk_in = 1'b0;
    bus.cs_n_in = 1'b1;
    bus.mosi_in = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", {2'b0, bus.miso_out, bus.miso_oe_out, bus.mem_addr_out, bus.mem_rd_en_out,
        bus.mem_wr_en_out, bus.mem_wdata_out, bus.busy_out, bus.cmd_error_out}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    mem[16'h1234] = 8'hA5;
    ref_mem[16'h1234] = 8'hA5;
    txn(8'h03, 24'h001234, 1, 0);
    chk("lit_a5", 32'(rbuf[0]), 32'h0000_00A5);
    chk("lit_rd_addr", 32'(rd_first), 32'h0000_1234);
    lat_fix = 0;
    mem[16'hFFFF] = 8'hFF; ref_mem[16'hFFFF] = 8'hFF;
    mem[16'h0000] = 8'h00; ref_mem[16'h0000] = 8'h00;
    mem[16'h0001] = 8'h01; ref_mem[16'h0001] = 8'h01;
    txn(8'h03, 24'h00FFFF, 3, 0);
    chk("lit_burst0", 32'(rbuf[0]), 32'h0000_00FF);
    chk("lit_burst1", 32'(rbuf[1]), 32'h0000_0000);
    chk("lit_burst2", 32'(rbuf[2]), 32'h0000_0001);
    wbuf[0] = 8'h3C;
    wbuf[1] = 8'h5A;
    r0 = rd_seen;
    w0 = wr_seen;
    txn(8'h02, 24'h000010, 2, 0);
    chk("lit_wr_count", 32'(wr_seen - w0), 2);
    chk("lit_wr_noread", 32'(rd_seen - r0), 0);
    chk("lit_mem10", 32'(mem[16'h0010]), 32'h0000_003C);
    chk("lit_mem11", 32'(mem[16'h0011]), 32'h0000_005A);
    e0 = err_seen;
    r0 = rd_seen;
    w0 = wr_seen;
    txn(8'h9F, 24'h0, 0, 0);
    chk("lit_bad_err", 32'(err_seen - e0), 1);
    chk("lit_bad_strobes", 32'(rd_seen - r0 + wr_seen - w0), 0);
    w0 = wr_seen;
    txn(8'h02, 24'h000400, 0, 5);
    chk("lit_abort_nowr", 32'(wr_seen - w0), 0);
    txn(8'h03, 24'h000010, 1, 0);
    chk("lit_after_abort", 32'(rbuf[0]), 32'h0000_003C);
    withhold = 1'b1;
    e0 = err_seen;
    txn(8'h03, 24'h000200, 1, 0);
    chk("lit_underrun", 32'(rbuf[0]), 0);
    chk("lit_underrun_err", 32'(err_seen - e0), 2);
    exp_rd.push_back(16'h0100);
    exp_rd.push_back(16'h0101);
    bus.cs_n_in = 1'b0;
    repeat (H) @(negedge clk);
    spi_byte(8'h03, x, 1'b0);
    spi_byte(8'h00, x, 1'b0);
    spi_byte(8'h01, x, 1'b0);
    oe_ok = 1'b1;
    spi_byte(8'h00, x, 1'b0);
    spi_byte(8'h00, x, 1'b1);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, y, 1'b1);
    chk("pre_rst_busy", 32'(bus.busy_out), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_oe", 32'(bus.miso_oe_out), 0);
    chk("rst_busy", 32'(bus.busy_out), 0);
    chk("rst_miso", 32'(bus.miso_out), 0);
    bus.sclk_in = 1'b0;
    bus.cs_n_in = 1'b1;
    exp_rd.delete();
    oe_ok = 1'b0;
    withhold = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      a = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      withhold = kind == 0 && $urandom_range(0, 7) == 0;
      if (kind == 0) txn(8'h03, a, n, 0);
      else if (kind == 1) txn(8'h02, a, n, 0);
      else if (kind == 2) begin
        op = 8'($urandom);
        while (op == 8'h02 || op == 8'h03) op = 8'($urandom);
        txn(op, a, 0, 0);
      end else txn(8'h02, a, n - 1, int'($urandom_range(1, 7)));
      withhold = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- SPI mode-0 slave that answers the memory-controller command set: READ 0x03 and WRITE 0x02, each with a 24-bit address, MSB first.
- It sits at the far end of the MCU's SPI memory bus. It emulates a PSRAM/flash chip on an FPGA test harness, backed by a simple on-chip memory port.
- SCLK, CS and MOSI are oversampled in the clk_in domain. No second clock is used.

Parameters:
- ADDR_W, 16: memory address width. The low ADDR_W bits of the 24-bit SPI address are used and the upper bits are ignored.
- SYNC_STAGES, 2: synchronizer depth on sclk_in, cs_n_in and mosi_in. Minimum 2.

Ports:
- clk_in  in  1  system clock. Requirement: f(clk_in) >= 8 x f(sclk_in).
- reset_in  in  1  asynchronous, active-high reset.
- sclk_in  in  1  SPI clock from the master. Idle low (mode 0).
- cs_n_in  in  1  chip select, active low.
- mosi_in  in  1  serial data from the master.
- miso_out  out  1  serial data to the master.
- miso_oe_out  out  1  output enable for the miso pad.
- mem_addr_out  out  ADDR_W  memory address.
- mem_rd_en_out  out  1  one-cycle read request.
- mem_wr_en_out  out  1  one-cycle write strobe.
- mem_wdata_out  out  8  write data.
- mem_rdata_in  in  8  read data.
- mem_rdata_valid_in  in  1  read data valid. Must arrive at most 2 clk_in cycles after mem_rd_en_out.
- busy_out  out  1  high while a transaction is in progress.
- cmd_error_out  out  1  one-cycle pulse on an unknown opcode or a read underrun.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and shift registers 0.
- Input sampling:
  - The three SPI inputs pass through SYNC_STAGES flops.
  - Edges are detected from the last stage against one extra delay flop.
  - Input-to-internal latency is SYNC_STAGES+1 cycles.
  - Rising sclk edge: sample MOSI. Falling sclk edge: update MISO.
- State machine: IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE.
- IDLE -> CMD when synced CS goes low. The bit counter clears.
- CMD: shift in 8 bits on rising edges.
  - 0x03 -> ADDR with the read flag set.
  - 0x02 -> ADDR with the write flag set.
  - Any other opcode -> IGNORE, with cmd_error_out pulsed for 1 cycle.
- ADDR: shift in 24 bits. On the 24th rising edge:
  - Latch addr = bits[ADDR_W-1:0].
  - Read: pulse mem_rd_en_out in the same cycle, with mem_addr_out = addr, then go to RD_DATA.
  - Write: go to WR_DATA.
- RD_DATA:
  - The returned byte is captured into a prefetch buffer on mem_rdata_valid_in.
  - On the falling edge that starts each byte (bit_cnt = 0), load the buffer into the shift register and drive bit 7. Each later falling edge drives the next bit.
  - On the 8th rising edge of a byte: addr = addr+1, wrapping modulo 2^ADDR_W, and a new mem_rd_en_out pulse is issued. This prefetches the next byte.
  - Underrun (no valid data by the byte-start falling edge): the byte is sent as 0x00 and cmd_error_out pulses. The transfer continues.
  - miso_oe_out = 1 from the first data falling edge until CS deasserts.
- WR_DATA:
  - Shift in 8 bits.
  - On the 8th rising edge: pulse mem_wr_en_out for 1 cycle, with mem_addr_out = addr and mem_wdata_out = the byte.
  - Then addr = addr+1 with wrap. Bursts are unlimited.
- IGNORE: MOSI is discarded, miso_out = 0, miso_oe_out = 0, and no memory activity occurs.
- In every state except RD_DATA, miso_out = 0 and miso_oe_out = 0.
- busy_out = (state != IDLE).
- Synced CS high in any state:
  - Next cycle: IDLE, miso_oe_out = 0, miso_out = 0.
  - A partial byte is discarded, with no write strobe.
  - An outstanding read response is ignored.
- CS rise and an sclk edge in the same cycle: CS wins and the edge is ignored.
- A later mem_rdata_valid_in while IDLE is ignored.
- mem_rd_en_out and mem_wr_en_out are never high in the same cycle.
- Asynchronous reset mid-transaction clears everything immediately. Outputs return to their reset values with no clock needed.

Test Plan:
- READ 0x03, addr 0x001234, memory returns 0xA5 after 1 cycle -> mem_rd_en_out pulses once with addr 0x1234. MISO bits over 8 falling edges are 1,0,1,0,0,1,0,1. miso_oe_out = 1 during data.
- Burst READ of 3 bytes from 0x00FFFF, memory returning addr[7:0] -> read addresses 0xFFFF, 0x0000, 0x0001 (wrap). MISO bytes are 0xFF, 0x00, 0x01.
- WRITE 0x02, addr 0x000010, data 0x3C then 0x5A -> write strobes (0x0010, 0x3C) and (0x0011, 0x5A). No read pulses.
- Opcode 0x9F followed by 32 clocks -> cmd_error_out pulses exactly once. No memory strobes. miso_oe_out stays 0. busy_out = 1 until CS rises.
- WRITE with CS raised after 5 data bits -> no mem_wr_en_out. busy_out = 0 within SYNC_STAGES+2 cycles. A following READ works normally.
- Read underrun (memory model withholds valid) -> data byte is 0x00 and cmd_error_out pulses. Asserting reset_in mid-burst drops miso_oe_out and busy_out asynchronously.
